// File: rtl/rs_pkg.sv
// Shared constants, entry layout and CDB capture helper for the reservation station.
package rs_pkg;

    localparam int unsigned RS_DEPTH   = 4;
    localparam int unsigned RS_INSTR_W = 16;
    localparam int unsigned RS_TAG_W   = 8;
    localparam int unsigned RS_DATA_W  = 128;

    typedef struct packed {
        logic [RS_TAG_W-1:0]  tag;
        logic                 rdy;
        logic [RS_DATA_W-1:0] data;
    } rs_operand_t;

    typedef struct packed {
        logic                  busy;
        logic [RS_INSTR_W-1:0] instr;
        logic [RS_TAG_W-1:0]   wb_tag;
        rs_operand_t           s0;
        rs_operand_t           s1;
    } rs_entry_t;

    // A waiting operand of a live entry picks up a matching broadcast result.
    function automatic rs_operand_t cdb_capture(
        input rs_operand_t          op,
        input logic                 live,
        input logic                 cdb_valid,
        input logic [RS_TAG_W-1:0]  cdb_tag,
        input logic [RS_DATA_W-1:0] cdb_data
    );
        rs_operand_t r;
        r = op;
        if (live && !op.rdy && cdb_valid && (op.tag == cdb_tag)) begin
            r.rdy  = 1'b1;
            r.data = cdb_data;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Allocation-order tracker: reports the oldest entry among an eligible set.
module rs_age_matrix #(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] eligible,
    output logic [DEPTH-1:0] oldest
);

    // older_q[i][j] set means entry i was allocated before entry j.
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];

    always_comb begin
        older_d = older_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (free[i]) older_d[i] = '0;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (alloc[k]) begin
                older_d[k] = '0;
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (j != k) older_d[j][k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else begin
            older_q <= older_d;
        end
    end

    always_comb begin
        oldest = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            oldest[i] = eligible[i];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (eligible[j] && older_q[j][i]) oldest[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/res_station.sv
// Reservation station: holds renamed ops until both operands are ready, issues oldest first.
module res_station
    import rs_pkg::*;
#(
    parameter int unsigned DEPTH   = RS_DEPTH,
    parameter int unsigned INSTR_W = RS_INSTR_W,
    parameter int unsigned TAG_W   = RS_TAG_W,
    parameter int unsigned DATA_W  = RS_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [INSTR_W-1:0]         alloc_instr,
    input  logic [TAG_W-1:0]           alloc_wb_tag,
    input  logic [TAG_W-1:0]           alloc_s0_tag,
    input  logic [TAG_W-1:0]           alloc_s1_tag,
    input  logic                       alloc_s0_rdy,
    input  logic                       alloc_s1_rdy,
    input  logic [DATA_W-1:0]          alloc_s0_data,
    input  logic [DATA_W-1:0]          alloc_s1_data,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [INSTR_W-1:0]         issue_instr,
    output logic [TAG_W-1:0]           issue_wb_tag,
    output logic [DATA_W-1:0]          issue_d0,
    output logic [DATA_W-1:0]          issue_d1,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rs_entry_t        ent_q [DEPTH];
    rs_entry_t        ent_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [DEPTH-1:0] busy, elig, free_oh, alloc_oh, issue_oh, sel_oh, age_alloc, age_free;
    logic             alloc_fire, issue_fire;
    rs_operand_t      src0, src1;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy[i] = ent_q[i].busy;
            elig[i] = ent_q[i].busy && ent_q[i].s0.rdy && ent_q[i].s1.rdy;
        end
    end

    assign alloc_ready = (count_q < CNT_W'(DEPTH));
    assign issue_valid = |elig;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign issue_fire  = issue_valid && issue_ready;
    assign count       = count_q;

    // Lowest-index free slot; slots freed by this cycle's issue still read busy.
    always_comb begin
        free_oh = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
        end
    end

    assign alloc_oh  = alloc_fire ? free_oh : '0;
    assign issue_oh  = issue_fire ? sel_oh : '0;
    assign age_alloc = flush ? '0 : alloc_oh;
    assign age_free  = flush ? '1 : issue_oh;

    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk      (clk),
        .rst      (rst),
        .alloc    (age_alloc),
        .free     (age_free),
        .eligible (elig),
        .oldest   (sel_oh)
    );

    // Incoming sources may be satisfied by the broadcast in flight this cycle.
    always_comb begin
        src0 = '{tag: RS_TAG_W'(alloc_s0_tag), rdy: alloc_s0_rdy, data: RS_DATA_W'(alloc_s0_data)};
        src1 = '{tag: RS_TAG_W'(alloc_s1_tag), rdy: alloc_s1_rdy, data: RS_DATA_W'(alloc_s1_data)};
        src0 = cdb_capture(src0, 1'b1, cdb_valid, RS_TAG_W'(cdb_tag), RS_DATA_W'(cdb_data));
        src1 = cdb_capture(src1, 1'b1, cdb_valid, RS_TAG_W'(cdb_tag), RS_DATA_W'(cdb_data));
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i]    = ent_q[i];
            ent_d[i].s0 = cdb_capture(ent_q[i].s0, ent_q[i].busy, cdb_valid,
                                      RS_TAG_W'(cdb_tag), RS_DATA_W'(cdb_data));
            ent_d[i].s1 = cdb_capture(ent_q[i].s1, ent_q[i].busy, cdb_valid,
                                      RS_TAG_W'(cdb_tag), RS_DATA_W'(cdb_data));
            if (issue_oh[i]) ent_d[i].busy = 1'b0;
            if (alloc_oh[i]) begin
                ent_d[i].busy   = 1'b1;
                ent_d[i].instr  = RS_INSTR_W'(alloc_instr);
                ent_d[i].wb_tag = RS_TAG_W'(alloc_wb_tag);
                ent_d[i].s0     = src0;
                ent_d[i].s1     = src1;
            end
            if (flush) begin
                ent_d[i].busy   = 1'b0;
                ent_d[i].s0.rdy = 1'b0;
                ent_d[i].s1.rdy = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            count_q <= flush ? '0 : count_q + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
        end
    end

    // One-hot select; all outputs read zero when nothing is eligible.
    always_comb begin
        issue_instr  = '0;
        issue_wb_tag = '0;
        issue_d0     = '0;
        issue_d1     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                issue_instr  = issue_instr  | INSTR_W'(ent_q[i].instr);
                issue_wb_tag = issue_wb_tag | TAG_W'(ent_q[i].wb_tag);
                issue_d0     = issue_d0     | DATA_W'(ent_q[i].s0.data);
                issue_d1     = issue_d1     | DATA_W'(ent_q[i].s1.data);
            end
        end
    end

endmodule

// File: tb/tb_res_station.sv
// Directed table-driven bench for res_station plus an asynchronous reset sequence.
module tb_res_station;

    logic         clk, rst, flush;
    logic         alloc_valid, alloc_ready;
    logic [15:0]  alloc_instr;
    logic [7:0]   alloc_wb_tag, alloc_s0_tag, alloc_s1_tag;
    logic         alloc_s0_rdy, alloc_s1_rdy;
    logic [127:0] alloc_s0_data, alloc_s1_data;
    logic         cdb_valid;
    logic [7:0]   cdb_tag;
    logic [127:0] cdb_data;
    logic         issue_valid, issue_ready;
    logic [15:0]  issue_instr;
    logic [7:0]   issue_wb_tag;
    logic [127:0] issue_d0, issue_d1;
    logic [2:0]   count;

    int checks = 0;
    int errors = 0;

    res_station dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_instr(alloc_instr),
        .alloc_wb_tag(alloc_wb_tag), .alloc_s0_tag(alloc_s0_tag), .alloc_s1_tag(alloc_s1_tag),
        .alloc_s0_rdy(alloc_s0_rdy), .alloc_s1_rdy(alloc_s1_rdy),
        .alloc_s0_data(alloc_s0_data), .alloc_s1_data(alloc_s1_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
        .issue_wb_tag(issue_wb_tag), .issue_d0(issue_d0), .issue_d1(issue_d1),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        av;
        logic [7:0]  wbt;
        logic [7:0]  s0t;
        logic        s0r;
        logic [31:0] s0d;
        logic [7:0]  s1t;
        logic        s1r;
        logic [31:0] s1d;
        logic        cv;
        logic [7:0]  ct;
        logic [31:0] cd;
        logic        ir;
        logic        fl;
        logic        ar;
        logic        iv;
        logic [7:0]  ewbt;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t idle(input logic ir);
        vec_t v;
        v    = '0;
        v.ir = ir;
        return v;
    endfunction

    function automatic vec_t al(input logic [7:0] wbt, input logic [7:0] s0t, input logic s0r,
                                input logic [31:0] s0d, input logic [7:0] s1t, input logic s1r,
                                input logic [31:0] s1d, input logic ir);
        vec_t v;
        v     = '0;
        v.av  = 1'b1;
        v.wbt = wbt;
        v.s0t = s0t; v.s0r = s0r; v.s0d = s0d;
        v.s1t = s1t; v.s1r = s1r; v.s1d = s1d;
        v.ir  = ir;
        return v;
    endfunction

    function automatic vec_t cdb(input vec_t s, input logic [7:0] ct, input logic [31:0] cd);
        vec_t v;
        v    = s;
        v.cv = 1'b1;
        v.ct = ct;
        v.cd = cd;
        return v;
    endfunction

    task automatic row(input vec_t s, input logic ar, input logic iv, input logic [7:0] ewbt,
                       input logic [31:0] ed0, input logic [31:0] ed1, input logic [2:0] cnt);
        vec_t v;
        v      = s;
        v.ar   = ar;   v.iv  = iv;  v.ewbt = ewbt;
        v.ed0  = ed0;  v.ed1 = ed1; v.cnt  = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        alloc_valid   = v.av;
        alloc_instr   = {8'h5A, v.wbt};
        alloc_wb_tag  = v.wbt;
        alloc_s0_tag  = v.s0t; alloc_s0_rdy = v.s0r; alloc_s0_data = 128'(v.s0d);
        alloc_s1_tag  = v.s1t; alloc_s1_rdy = v.s1r; alloc_s1_data = 128'(v.s1d);
        cdb_valid     = v.cv;  cdb_tag = v.ct;  cdb_data = 128'(v.cd);
        issue_ready   = v.ir;
        flush         = v.fl;
    endtask

    initial begin
        vec_t f;
        // In-order allocation and drain
        row(idle(0),                          1, 0, 8'h00, 32'h00, 32'h00, 0);
        row(al(8'hA0, 0, 1, 32'h10, 0, 1, 32'h20, 0), 1, 0, 8'h00, 0, 0, 0);
        row(al(8'hA1, 0, 1, 32'h11, 0, 1, 32'h21, 0), 1, 1, 8'hA0, 32'h10, 32'h20, 1);
        row(al(8'hA2, 0, 1, 32'h12, 0, 1, 32'h22, 0), 1, 1, 8'hA0, 32'h10, 32'h20, 2);
        row(al(8'hA3, 0, 1, 32'h13, 0, 1, 32'h23, 0), 1, 1, 8'hA0, 32'h10, 32'h20, 3);
        row(idle(1),                          0, 1, 8'hA0, 32'h10, 32'h20, 4);
        row(idle(1),                          1, 1, 8'hA1, 32'h11, 32'h21, 3);
        row(idle(1),                          1, 1, 8'hA2, 32'h12, 32'h22, 2);
        row(idle(1),                          1, 1, 8'hA3, 32'h13, 32'h23, 1);
        row(idle(0),                          1, 0, 8'h00, 0, 0, 0);
        // Wakeup by broadcast; unrelated tag first
        row(al(8'hB0, 8'h12, 0, 0, 0, 1, 32'h55, 0), 1, 0, 8'h00, 0, 0, 0);
        row(cdb(idle(0), 8'h33, 32'hDEAD),    1, 0, 8'h00, 0, 0, 1);
        row(cdb(idle(0), 8'h12, 32'hABCD),    1, 0, 8'h00, 0, 0, 1);
        row(idle(1),                          1, 1, 8'hB0, 32'hABCD, 32'h55, 1);
        row(idle(0),                          1, 0, 8'h00, 0, 0, 0);
        // Allocation bypass
        row(cdb(al(8'hC0, 0, 1, 32'h3, 8'h05, 0, 0, 0), 8'h05, 32'h7), 1, 0, 8'h00, 0, 0, 0);
        row(idle(1),                          1, 1, 8'hC0, 32'h3, 32'h7, 1);
        row(idle(0),                          1, 0, 8'h00, 0, 0, 0);
        // Full station: alloc rejected while issuing
        row(al(8'hE0, 0, 1, 32'h30, 0, 1, 32'h40, 0), 1, 0, 8'h00, 0, 0, 0);
        row(al(8'hE1, 0, 1, 32'h31, 0, 1, 32'h41, 0), 1, 1, 8'hE0, 32'h30, 32'h40, 1);
        row(al(8'hE2, 0, 1, 32'h32, 0, 1, 32'h42, 0), 1, 1, 8'hE0, 32'h30, 32'h40, 2);
        row(al(8'hE3, 0, 1, 32'h33, 0, 1, 32'h43, 0), 1, 1, 8'hE0, 32'h30, 32'h40, 3);
        row(al(8'hF0, 0, 1, 32'h99, 0, 1, 32'h99, 1), 0, 1, 8'hE0, 32'h30, 32'h40, 4);
        row(idle(0),                          1, 1, 8'hE1, 32'h31, 32'h41, 3);
        row(idle(1),                          1, 1, 8'hE1, 32'h31, 32'h41, 3);
        row(idle(1),                          1, 1, 8'hE2, 32'h32, 32'h42, 2);
        row(idle(1),                          1, 1, 8'hE3, 32'h33, 32'h43, 1);
        row(idle(0),                          1, 0, 8'h00, 0, 0, 0);
        // Age order: older waiting entry sits at a higher index than a newer ready one
        row(al(8'h50, 0, 1, 32'h60, 0, 1, 32'h61, 0), 1, 0, 8'h00, 0, 0, 0);
        row(al(8'h60, 8'h21, 0, 0, 0, 1, 32'h1, 0),   1, 1, 8'h50, 32'h60, 32'h61, 1);
        row(al(8'h61, 0, 1, 32'h2, 0, 1, 32'h3, 1),   1, 1, 8'h50, 32'h60, 32'h61, 2);
        row(idle(1),                          1, 1, 8'h61, 32'h2, 32'h3, 2);
        row(cdb(al(8'h62, 0, 1, 32'h4, 0, 1, 32'h5, 0), 8'h21, 32'h99), 1, 0, 8'h00, 0, 0, 1);
        row(idle(1),                          1, 1, 8'h60, 32'h99, 32'h1, 2);
        row(idle(1),                          1, 1, 8'h62, 32'h4, 32'h5, 1);
        row(idle(0),                          1, 0, 8'h00, 0, 0, 0);
        // Flush with concurrent alloc and issue
        row(al(8'h70, 0, 1, 32'h70, 0, 1, 32'h71, 0), 1, 0, 8'h00, 0, 0, 0);
        row(al(8'h71, 0, 1, 32'h72, 0, 1, 32'h73, 0), 1, 1, 8'h70, 32'h70, 32'h71, 1);
        row(al(8'h72, 0, 1, 32'h74, 0, 1, 32'h75, 0), 1, 1, 8'h70, 32'h70, 32'h71, 2);
        f = al(8'h7F, 0, 1, 32'h1, 0, 1, 32'h2, 1);
        f.fl = 1'b1;
        row(f,                                1, 1, 8'h70, 32'h70, 32'h71, 3);
        row(idle(0),                          1, 0, 8'h00, 0, 0, 0);
        row(idle(1),                          1, 0, 8'h00, 0, 0, 0);
        // One broadcast wakes every matching operand
        row(al(8'h80, 8'h44, 0, 0, 0, 1, 32'h10, 0),     1, 0, 8'h00, 0, 0, 0);
        row(al(8'h81, 8'h44, 0, 0, 8'h44, 0, 0, 0),      1, 0, 8'h00, 0, 0, 1);
        row(cdb(idle(0), 8'h44, 32'h77),      1, 0, 8'h00, 0, 0, 2);
        row(idle(1),                          1, 1, 8'h80, 32'h77, 32'h10, 2);
        row(idle(1),                          1, 1, 8'h81, 32'h77, 32'h77, 1);
        row(idle(0),                          1, 0, 8'h00, 0, 0, 0);

        rst = 1'b0;
        drive(idle(0));
        repeat (3) @(negedge clk);
        chk("reset_count", -1, 128'(count), 128'd0);
        chk("reset_alloc_ready", -1, 128'(alloc_ready), 128'd1);
        chk("reset_issue_valid", -1, 128'(issue_valid), 128'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk("alloc_ready",  i, 128'(alloc_ready),  128'(vecs[i].ar));
            chk("issue_valid",  i, 128'(issue_valid),  128'(vecs[i].iv));
            chk("issue_wb_tag", i, 128'(issue_wb_tag), 128'(vecs[i].ewbt));
            chk("issue_instr",  i, 128'(issue_instr),
                vecs[i].iv ? 128'({8'h5A, vecs[i].ewbt}) : 128'd0);
            chk("issue_d0",     i, issue_d0, 128'(vecs[i].ed0));
            chk("issue_d1",     i, issue_d1, 128'(vecs[i].ed1));
            chk("count",        i, 128'(count), 128'(vecs[i].cnt));
        end

        // Asynchronous reset between edges discards live entries immediately
        @(negedge clk);
        drive(al(8'h90, 0, 1, 32'h1, 0, 1, 32'h2, 0));
        @(negedge clk);
        drive(al(8'h91, 0, 1, 32'h3, 0, 1, 32'h4, 0));
        @(negedge clk);
        drive(idle(1));
        #1;
        chk("pre_rst_count", -2, 128'(count), 128'd2);
        chk("pre_rst_issue_valid", -2, 128'(issue_valid), 128'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_count", -2, 128'(count), 128'd0);
        chk("async_rst_issue_valid", -2, 128'(issue_valid), 128'd0);
        chk("async_rst_alloc_ready", -2, 128'(alloc_ready), 128'd1);
        chk("async_rst_d0", -2, issue_d0, 128'd0);
        @(posedge clk);
        #1;
        chk("hold_rst_issue_valid", -2, 128'(issue_valid), 128'd0);
        @(negedge clk);
        drive(idle(0));
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_count", -2, 128'(count), 128'd0);
        chk("post_rst_issue_valid", -2, 128'(issue_valid), 128'd0);
        chk("post_rst_alloc_ready", -2, 128'(alloc_ready), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
